arb4_rr_grant: RTL and testbench
================================

# arb4_rr_grant

Four-requester arbiter that shares a single downstream resource among requesters `req[3:0]`. It is built around the same 4-input priority-encoding function as the combinational priority encoder. The arbiter adds a registered grant, a grant-hold state machine with a bounded hold time, and a selectable round-robin mode so that no requester starves. It sits between the requesting units and the shared datapath and drives that datapath's select from `gnt_id`.

## Interface
- `MAX_HOLD`, 8: maximum consecutive grant cycles per ownership. 0 means unlimited. Legal range is 0..2^`HOLD_W`-1.
- `HOLD_W`, 4: width of the hold counter.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset. **Synchronous and active-low, as already decided.**
- `req`  in  4  request vector, level-held by each requester until it is done.
- `mode`  in  1  0 = fixed priority (`req[3]` highest, `req[0]` lowest); 1 = round-robin.
- `gnt`  out  4  one-hot grant, registered. All-zero when nothing is granted.
- `gnt_id`  out  2  binary index of the granted requester; 0 when `gnt_valid`=0.
- `gnt_valid`  out  1  equals OR of `gnt`, registered.
- `gnt_end`  out  1  one-cycle pulse in the first cycle after any grant ends.

## Operation
- **States.** Two states: IDLE and GRANT. Internal state is `ptr[1:0]` (round-robin pointer), `cnt[HOLD_W-1:0]` and the current owner `id`.
- **Winner selection.** Combinational, evaluated only in IDLE.
  - Fixed mode: scan order is 3, 2, 1, 0.
  - Round-robin mode: scan order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4).
  - The winner is the first requester in scan order whose `req` bit is 1.
- **IDLE → GRANT.** At an edge where `req`≠0:
  - `gnt` <= onehot(winner), `gnt_id` <= winner, `gnt_valid` <= 1, `cnt` <= 1.
  - If `mode`=1: `ptr` <= winner+1 (mod 4). If `mode`=0: `ptr` is unchanged.
- **IDLE with `req`=0.** Stay in IDLE; `gnt`=0.
- **GRANT → IDLE.** At an edge where `req[id]`=0, or where `MAX_HOLD`≠0 and `cnt`==`MAX_HOLD`:
  - `gnt` <= 0, `gnt_id` <= 0, `gnt_valid` <= 0, `gnt_end` <= 1.
- **GRANT hold.** Otherwise stay in GRANT and `cnt` <= `cnt`+1.
- **Counter wrap.** With `MAX_HOLD`=0 the counter saturates at all-ones and never forces a release.
- **`gnt_end`.** High for exactly the one IDLE cycle that follows a GRANT; 0 at all other times.
- **`mode` sampling.** `mode` is sampled only at the IDLE→GRANT edge. A change during GRANT has no effect on the current owner.
- **Preemption.** A requester forced off by `MAX_HOLD` keeps `req` high and re-competes.
  - In fixed mode, `req[3]` held high wins every arbitration. This starvation of lower requesters is the specified behaviour.
  - Round-robin guarantees each active requester a grant within 4 arbitrations.
- **Grant-line changes.** Requests from non-owners during GRANT are ignored and never glitch `gnt`.

## Timing
- **Reset.** When `rst_n`=0 at an edge: state IDLE, `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `gnt_end`=0, `ptr`=0, `cnt`=0.
  - Reset during GRANT drops `gnt` at that same edge, with no `gnt_end` pulse.
  - `req` is ignored while `rst_n`=0.
- **Grant latency.** `req` first sampled high at edge k → `gnt` high after edge k, i.e. 1 cycle.
- **Release latency.** `req[id]` sampled low at edge k → `gnt` low after edge k.
- **Hold length.** A requester holding `req` continuously owns the resource for exactly `MAX_HOLD` cycles.
- **Turnaround gap.** There is a minimum 1-cycle gap (the `gnt_end` cycle) with `gnt`=0 between any two grants, even to different owners. The next grant can appear at the edge ending that gap.
- **Output registration.** All outputs are registered; there is no combinational path from `req` to `gnt`.

## Test plan
- **Reset.** Assert `rst_n`=0 for 2 cycles with `req`=4'b1111 → `gnt`=0, `gnt_valid`=0, `gnt_end`=0 throughout. After release, with `mode`=0, `gnt`=4'b1000 one cycle later.
- **Fixed-priority release sequence.** `mode`=0, `req`=4'b0110 held, then drop bits in turn.
  - First grant: `gnt`=4'b0100, `gnt_id`=2.
  - Drop `req[2]`: `gnt`=0 and `gnt_end`=1 for 1 cycle, then `gnt`=4'b0010.
  - Drop `req[1]`: `gnt_end` pulse, then IDLE.
- **MAX_HOLD preemption.** `MAX_HOLD`=3, `mode`=0, `req`=4'b1001 held.
  - `gnt`=4'b1000 for exactly 3 cycles, 1 gap cycle, then `gnt`=4'b1000 again.
  - `req[0]` is never granted.
- **Round-robin rotation.** `MAX_HOLD`=2, `mode`=1, `req`=4'b1111 held from reset.
  - Grant order is ids 0, 1, 2, 3, 0, each granted for 2 cycles with 1-cycle gaps.
  - `ptr` advances to 1, 2, 3, 0, 1.
- **Mid-grant changes.** `mode`=1, owner id 1 with `req`=4'b0010.
  - Raise `req[3]` and toggle `mode` to 0 mid-grant → `gnt` stays 4'b0010 until `req[1]` drops.
  - Next grant is `gnt`=4'b1000.
- **Reset during grant, and unlimited hold.**
  - Reset mid-grant (`gnt`=4'b0001): `gnt`=0 after that edge with no `gnt_end` pulse, and `ptr` returns to 0.
  - Then set `MAX_HOLD`=0 and hold `req[0]` for 40 cycles → continuous grant, `cnt` saturates, no release.

Source files
------------

// File: rtl/arb4_rr_grant.sv
// arb4_rr_grant: 4-way arbiter, fixed priority or round-robin, with registered grant and bounded hold
module arb4_rr_grant #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       mode,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       gnt_end
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [HOLD_W-1:0] LIMIT = HOLD_W'(MAX_HOLD);
  state_t state;
  logic [1:0] ptr, win, idx;
  logic [HOLD_W-1:0] cnt;
  logic release_now;
  // walk the scan order backwards so the earliest requester in order wins
  always_comb begin
    win = 2'd0;
    idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = mode ? ptr + 2'(k) : 2'(3 - k);
      if (req[idx]) win = idx;
    end
  end
  assign release_now = !req[gnt_id] || (MAX_HOLD != 0 && cnt == LIMIT);
  always_ff @(posedge clk)
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= 4'b0;
      gnt_id    <= 2'd0;
      gnt_valid <= 1'b0;
      gnt_end   <= 1'b0;
      ptr       <= 2'd0;
      cnt       <= '0;
    end else if (state == IDLE) begin
      gnt_end <= 1'b0;
      if (|req) begin
        state     <= GRANT;
        gnt       <= 4'b1 << win;
        gnt_id    <= win;
        gnt_valid <= 1'b1;
        cnt       <= HOLD_W'(1);
        if (mode) ptr <= win + 2'd1;
      end
    end else if (release_now) begin
      state     <= IDLE;
      gnt       <= 4'b0;
      gnt_id    <= 2'd0;
      gnt_valid <= 1'b0;
      gnt_end   <= 1'b1;
    end else
      cnt <= &cnt ? cnt : cnt + 1'b1;
endmodule

// File: tb/tb_arb4_rr_grant.sv
// tb_arb4_rr_grant: four arbiters with different hold limits checked each cycle against a behavioural model
module tb_arb4_rr_grant;
  function automatic int mh(input int i);
    return i == 0 ? 8 : i == 1 ? 3 : i == 2 ? 2 : 0;
  endfunction
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0;
  logic       mode = 1'b0;
  logic [3:0] gnt [4];
  logic [1:0] gid [4];
  logic       gv  [4];
  logic       ge  [4];
  int owner [4];
  int held  [4];
  int rr    [4];
  int endf  [4];
  int seen = 0;
  int passed = 0;
  int total = 0;
  logic [3:0] rr_exp [13] = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    arb4_rr_grant #(.MAX_HOLD(mh(g)), .HOLD_W(4)) u (
      .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
      .gnt(gnt[g]), .gnt_id(gid[g]), .gnt_valid(gv[g]), .gnt_end(ge[g])
    );
  end

  // owner is -1 when idle; ptr is the first index scanned in round-robin mode
  always @(posedge clk)
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        owner[i] = -1;
        held[i] = 0;
        rr[i] = 0;
        endf[i] = 0;
        seen = 1;
      end else if (owner[i] < 0) begin
        endf[i] = 0;
        for (int k = 0; k < 4; k++) begin
          int c;
          c = mode ? (rr[i] + k) % 4 : 3 - k;
          if (owner[i] < 0 && req[c]) owner[i] = c;
        end
        if (owner[i] >= 0) begin
          held[i] = 1;
          if (mode) rr[i] = (owner[i] + 1) % 4;
        end
      end else if (!req[owner[i]] || (mh(i) != 0 && held[i] >= mh(i))) begin
        owner[i] = -1;
        endf[i] = 1;
      end else
        held[i]++;
    end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (seen != 0)
      for (int i = 0; i < 4; i++) begin
        logic [7:0] e;
        e[7:4] = owner[i] < 0 ? 4'b0 : 4'(1 << owner[i]);
        e[3:2] = owner[i] < 0 ? 2'd0 : 2'(owner[i]);
        e[1]   = owner[i] >= 0;
        e[0]   = endf[i] != 0;
        check($sformatf("cycle_inst%0d", i), {24'b0, gnt[i], gid[i], gv[i], ge[i]}, {24'b0, e});
      end
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b1111; mode = 1'b0;
    tick(); tick();
    check("rst_gnt", 32'(gnt[0]), 32'h0);
    check("rst_valid", 32'(gv[0]), 32'h0);
    check("rst_end", 32'(ge[0]), 32'h0);
    rst_n = 1'b1;
    tick();
    check("rst_release_gnt", 32'(gnt[0]), 32'h8);

    rst_n = 1'b0; tick();
    rst_n = 1'b1; req = 4'b0110; tick();
    check("fixed_first_gnt", 32'(gnt[0]), 32'h4);
    check("fixed_first_id", 32'(gid[0]), 32'h2);
    req = 4'b0010; tick();
    check("fixed_drop2_gnt", 32'(gnt[0]), 32'h0);
    check("fixed_drop2_end", 32'(ge[0]), 32'h1);
    tick();
    check("fixed_second_gnt", 32'(gnt[0]), 32'h2);
    req = 4'b0000; tick();
    check("fixed_drop1_end", 32'(ge[0]), 32'h1);
    tick();
    check("fixed_idle_end", 32'(ge[0]), 32'h0);

    rst_n = 1'b0; req = 4'b1001; mode = 1'b0; tick();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check($sformatf("hold3_c%0d", c), 32'(gnt[1]), c % 4 == 3 ? 32'h0 : 32'h8);
    end

    rst_n = 1'b0; mode = 1'b1; req = 4'b1111; tick();
    rst_n = 1'b1;
    for (int c = 0; c < 13; c++) begin
      tick();
      check($sformatf("rr_c%0d", c), 32'(gnt[2]), 32'(rr_exp[c]));
    end

    rst_n = 1'b0; tick();
    rst_n = 1'b1; mode = 1'b1; req = 4'b0010; tick();
    check("mid_owner", 32'(gnt[0]), 32'h2);
    req = 4'b1010; mode = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("mid_hold_c%0d", c), 32'(gnt[0]), 32'h2);
    end
    req = 4'b1000; tick();
    check("mid_release_end", 32'(ge[0]), 32'h1);
    tick();
    check("mid_next_gnt", 32'(gnt[0]), 32'h8);

    rst_n = 1'b0; tick();
    rst_n = 1'b1; mode = 1'b1; req = 4'b0001; tick();
    check("rstg_owner", 32'(gnt[0]), 32'h1);
    rst_n = 1'b0; tick();
    check("rstg_gnt", 32'(gnt[0]), 32'h0);
    check("rstg_end", 32'(ge[0]), 32'h0);
    rst_n = 1'b1; req = 4'b1111; tick();
    check("ptr_reset_gnt", 32'(gnt[0]), 32'h1);
    req = 4'b0001;
    for (int c = 0; c < 40; c++) begin
      tick();
      check($sformatf("unlim_c%0d", c), 32'(gnt[3]), 32'h1);
    end
    check("unlim_cnt_sat", 32'(g_dut[3].u.cnt), 32'hf);

    for (int c = 0; c < 3000; c++) begin
      rst_n = $urandom_range(63) != 0;
      if ($urandom_range(3) == 0) req = req ^ 4'($urandom);
      if ($urandom_range(15) == 0) mode = ~mode;
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
